io_input_sequencer: RTL and testbench

Sequences the processor's switch-input instruction. While the decoded input opcode is active, the block stalls the program counter and register write. It waits for a debounced press of the confirm key, latches the switch bank, and releases the core for exactly one cycle with the captured value. The block sits between the control unit, the PC stall input and the register-bank write mux, and replaces free-running switch sampling with a press-confirmed handshake.

---
 rtl/io_seq_pkg.sv | 16 +
 rtl/io_input_sequencer_sync2.sv | 28 ++
 rtl/io_input_sequencer.sv | 119 +++++++++++
 tb/tb_io_input_sequencer.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/io_seq_pkg.sv
// Shared types and constants for the switch-input sequencer.
// The input opcode is used by the decoder that drives in_req.
package io_seq_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        WAIT_PRESS   = 2'd1,
        DONE         = 2'd2,
        WAIT_RELEASE = 2'd3
    } seqState_t;

    localparam int          DEF_SW_W            = 18;
    localparam int          DEF_DEBOUNCE_CYCLES = 4;
    localparam logic [5:0]  OP_INPUT            = 6'b010110;

endpackage

// File: rtl/io_input_sequencer_sync2.sv
// Parameterized-width two-flop synchronizer with a configurable reset value.
// Each bit is synchronized independently; multi-bit values must be quasi-static.
module sync2 #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage1;
    logic [WIDTH-1:0] stage2;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stage1 <= RESET_VAL;
            stage2 <= RESET_VAL;
        end else begin
            stage1 <= d;
            stage2 <= stage1;
        end
    end

    assign q = stage2;

endmodule

// File: rtl/io_input_sequencer.sv
// Press-confirmed switch input: stalls the core until a debounced key press,
// then releases it for one cycle with the captured switch value.
module io_input_sequencer
    import io_seq_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int SW_W            = DEF_SW_W,
    parameter int CNT_W           = 16
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            in_req,
    input  logic            key_n,
    input  logic [SW_W-1:0] sw,
    output logic            stall,
    output logic            data_valid,
    output logic [31:0]     data
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic            keySync;
    logic [SW_W-1:0] swSync;

    seqState_t        stateReg, stateNext;
    logic [CNT_W-1:0] cntReg, cntNext;
    logic [31:0]      dataReg, dataNext;

    sync2 #(.WIDTH(1), .RESET_VAL(1'b1)) keySyncInst (
        .clock (clock),
        .reset (reset),
        .d     (key_n),
        .q     (keySync)
    );

    sync2 #(.WIDTH(SW_W), .RESET_VAL('0)) swSyncInst (
        .clock (clock),
        .reset (reset),
        .d     (sw),
        .q     (swSync)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stateReg <= IDLE;
            cntReg   <= '0;
            dataReg  <= '0;
        end else begin
            stateReg <= stateNext;
            cntReg   <= cntNext;
            dataReg  <= dataNext;
        end
    end

    always_comb begin
        stateNext = stateReg;
        cntNext   = cntReg;
        dataNext  = dataReg;
        case (stateReg)
            IDLE: begin
                cntNext = '0;
                // A key already held when the request appears must be released first.
                if (in_req) stateNext = keySync ? WAIT_PRESS : WAIT_RELEASE;
            end
            WAIT_PRESS: begin
                if (!in_req) begin
                    stateNext = IDLE;
                    cntNext   = '0;
                end else if (!keySync) begin
                    if (cntReg == CNT_LAST) begin
                        stateNext = DONE;
                        cntNext   = '0;
                        dataNext  = 32'(swSync);
                    end else begin
                        cntNext = cntReg + 1'b1;
                    end
                end else begin
                    cntNext = '0;
                end
            end
            DONE: begin
                stateNext = WAIT_RELEASE;
                cntNext   = '0;
            end
            WAIT_RELEASE: begin
                if (keySync) begin
                    if (cntReg == CNT_LAST) begin
                        stateNext = IDLE;
                        cntNext   = '0;
                    end else begin
                        cntNext = cntReg + 1'b1;
                    end
                end else begin
                    cntNext = '0;
                end
            end
            default: begin
                stateNext = IDLE;
                cntNext   = '0;
            end
        endcase
    end

    always_comb begin
        stall      = in_req;
        data_valid = 1'b0;
        case (stateReg)
            WAIT_PRESS: stall = 1'b1;
            DONE: begin
                stall      = 1'b0;
                data_valid = 1'b1;
            end
            default: stall = in_req;
        endcase
    end

    assign data = dataReg;

endmodule

// File: tb/tb_io_input_sequencer.sv
// Directed and randomized checks of io_input_sequencer against a run-length
// reference model of the press/release handshake.
module tb_io_input_sequencer;

    localparam int D    = 4;
    localparam int SW_W = 18;

    logic            clock = 1'b0;
    logic            reset;
    logic            in_req;
    logic            key_n;
    logic [SW_W-1:0] sw;
    logic            stall;
    logic            data_valid;
    logic [31:0]     data;

    io_input_sequencer #(.DEBOUNCE_CYCLES(D), .SW_W(SW_W), .CNT_W(16)) dut (
        .clock      (clock),
        .reset      (reset),
        .in_req     (in_req),
        .key_n      (key_n),
        .sw         (sw),
        .stall      (stall),
        .data_valid (data_valid),
        .data       (data)
    );

    always #5 clock = ~clock;

    int testCount = 0;
    int failCount = 0;
    int dvCount   = 0;

    // Reference model: phases with a run length of qualifying key levels.
    localparam int PH_IDLE = 0, PH_ARMED = 1, PH_FIRE = 2, PH_REARM = 3;
    int              mPhase;
    int              mRun;
    logic [31:0]     mData;
    logic            mKeyPipe [2];
    logic [SW_W-1:0] mSwPipe  [2];

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        testCount++;
        if (got !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic modelReset();
        mPhase      = PH_IDLE;
        mRun        = 0;
        mData       = 32'h0;
        mKeyPipe[0] = 1'b1;
        mKeyPipe[1] = 1'b1;
        mSwPipe[0]  = '0;
        mSwPipe[1]  = '0;
    endtask

    // One clock edge of the model using the inputs held across that edge.
    task automatic modelAdvance();
        logic keyS;
        keyS = mKeyPipe[1];
        case (mPhase)
            PH_IDLE:
                if (in_req) begin
                    mPhase = keyS ? PH_ARMED : PH_REARM;
                    mRun   = 0;
                end
            PH_ARMED:
                if (!in_req) begin
                    mPhase = PH_IDLE;
                    mRun   = 0;
                end else if (!keyS) begin
                    mRun++;
                    if (mRun == D) begin
                        mPhase = PH_FIRE;
                        mRun   = 0;
                        mData  = {{(32-SW_W){1'b0}}, mSwPipe[1]};
                    end
                end else begin
                    mRun = 0;
                end
            PH_FIRE: begin
                mPhase = PH_REARM;
                mRun   = 0;
            end
            default:
                if (keyS) begin
                    mRun++;
                    if (mRun == D) begin
                        mPhase = PH_IDLE;
                        mRun   = 0;
                    end
                end else begin
                    mRun = 0;
                end
        endcase
        mKeyPipe[1] = mKeyPipe[0];
        mKeyPipe[0] = key_n;
        mSwPipe[1]  = mSwPipe[0];
        mSwPipe[0]  = sw;
    endtask

    // Inputs are already driven; check outputs, take one edge, return at negedge.
    task automatic step();
        logic expStall;
        if (!reset) modelReset();
        #1;
        expStall = (mPhase == PH_ARMED) ? 1'b1 : (mPhase == PH_FIRE) ? 1'b0 : in_req;
        checkVal("stall", 32'(stall), 32'(expStall));
        checkVal("data_valid", 32'(data_valid), 32'(mPhase == PH_FIRE));
        checkVal("data", data, mData);
        @(posedge clock);
        if (reset) modelAdvance(); else modelReset();
        @(negedge clock);
        if (data_valid) dvCount++;
    endtask

    task automatic drive(input logic req, input logic kn, input logic [SW_W-1:0] s, input int n);
        in_req = req;
        key_n  = kn;
        sw     = s;
        reset  = 1'b1;
        for (int i = 0; i < n; i++) step();
    endtask

    // Steps with current inputs until data_valid is seen, bounded.
    task automatic waitPulse(output int edges);
        edges = 0;
        while (edges < 20) begin
            step();
            edges++;
            if (data_valid) break;
        end
    endtask

    int edges;
    int dvBefore;

    initial begin
        reset  = 1'b0;
        in_req = 1'b0;
        key_n  = 1'b1;
        sw     = '0;
        modelReset();
        @(negedge clock);

        // Reset state
        #1;
        checkVal("rst_stall", 32'(stall), 32'h0);
        checkVal("rst_dv", 32'(data_valid), 32'h0);
        checkVal("rst_data", data, 32'h0);
        in_req = 1'b1;
        #1;
        checkVal("rst_stall_req", 32'(stall), 32'h1);
        step();

        // Clean press
        drive(1'b1, 1'b1, 18'h15A5A, 4);
        key_n = 1'b0;
        waitPulse(edges);
        $display("[TB] clean press: edges=%0d data=%h stall=%0b", edges, data, stall);
        checkVal("press_latency", 32'(edges), 32'd6);
        checkVal("press_data", data, 32'h00015A5A);
        checkVal("press_stall", 32'(stall), 32'h0);
        drive(1'b0, 1'b1, 18'h15A5A, 10);

        // Abort after two pressed cycles
        dvBefore = dvCount;
        drive(1'b1, 1'b1, 18'h3FFFF, 3);
        drive(1'b1, 1'b0, 18'h3FFFF, 4);
        drive(1'b0, 1'b0, 18'h3FFFF, 2);
        $display("[TB] abort: pulses=%0d data=%h", dvCount - dvBefore, data);
        checkVal("abort_no_pulse", 32'(dvCount - dvBefore), 32'd0);
        checkVal("abort_data", data, 32'h00015A5A);
        drive(1'b0, 1'b1, 18'h3FFFF, 10);

        // Bounce: raw 0,0,1 then steady 0
        dvBefore = dvCount;
        drive(1'b1, 1'b1, 18'h0F0F0, 4);
        drive(1'b1, 1'b0, 18'h0F0F0, 2);
        drive(1'b1, 1'b1, 18'h0F0F0, 1);
        checkVal("bounce_no_early", 32'(dvCount - dvBefore), 32'd0);
        key_n = 1'b0;
        waitPulse(edges);
        $display("[TB] bounce: edges=%0d data=%h", edges, data);
        checkVal("bounce_latency", 32'(edges), 32'd6);
        checkVal("bounce_data", data, 32'h0000F0F0);

        // Held key satisfies no new request until released and pressed again
        dvBefore = dvCount;
        drive(1'b1, 1'b0, 18'h2C3C3, 10);
        checkVal("held_no_pulse", 32'(dvCount - dvBefore), 32'd0);
        drive(1'b1, 1'b1, 18'h2C3C3, 8);
        key_n = 1'b0;
        waitPulse(edges);
        $display("[TB] held key repress: edges=%0d data=%h", edges, data);
        checkVal("held_latency", 32'(edges), 32'd6);
        checkVal("held_data", data, 32'h0002C3C3);
        drive(1'b0, 1'b1, 18'h2C3C3, 10);

        // Reset in the middle of debounce
        dvBefore = dvCount;
        drive(1'b1, 1'b1, 18'h11111, 3);
        drive(1'b1, 1'b0, 18'h11111, 4);
        reset = 1'b0;
        step();
        $display("[TB] mid reset: data=%h dv=%0b", data, data_valid);
        checkVal("midrst_data", data, 32'h0);
        checkVal("midrst_no_pulse", 32'(dvCount - dvBefore), 32'd0);
        drive(1'b1, 1'b1, 18'h11111, 8);
        key_n = 1'b0;
        waitPulse(edges);
        checkVal("midrst_repress", 32'(edges), 32'd6);
        checkVal("midrst_data2", data, 32'h00011111);
        drive(1'b0, 1'b1, 18'h11111, 10);

        // Randomized traffic against the model
        begin
            int keyHold = 0;
            for (int c = 0; c < 3000; c++) begin
                reset = ($urandom_range(399) != 0);
                if ($urandom_range(39) == 0) in_req = ~in_req;
                if ($urandom_range(9) == 0) sw = SW_W'($urandom);
                if (keyHold == 0) begin
                    key_n   = ~key_n;
                    keyHold = ($urandom_range(3) == 0) ? $urandom_range(2, 1) : $urandom_range(12, 3);
                end
                keyHold--;
                step();
            end
        end
        $display("[TB] random phase done, pulses seen=%0d", dvCount);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
